// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: PC-unit handshake, byte-wide memory read port and decoder-side outputs.
// master is the fetch unit's view; slave is the view of the surrounding PC/memory/decoder.
interface inst_fetch_if #(
    parameter int unsigned addrWidth = 32,
    parameter int unsigned instWidth = 32
);
    logic [addrWidth-1:0] PC;
    logic                 PC_stall;
    logic                 mem_req;
    logic [addrWidth-1:0] mem_addr;
    logic                 mem_rvalid;
    logic [7:0]           mem_rdata;
    logic                 id_stall;
    logic                 flush;
    logic [instWidth-1:0] inst;
    logic [addrWidth-1:0] inst_pc;
    logic                 inst_valid;

    modport master (
        input  PC, mem_rvalid, mem_rdata, id_stall, flush,
        output PC_stall, mem_req, mem_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        output PC, mem_rvalid, mem_rdata, id_stall, flush,
        input  PC_stall, mem_req, mem_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four little-endian byte reads and
// hands it to the decoder through a single registered output slot.
module inst_fetch #(
    parameter int unsigned addrWidth = 32,
    parameter int unsigned instWidth = 32
) (
    input logic        clk,
    input logic        rst,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StFull} state_e;

    state_e               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [instWidth-1:0] buf_q, buf_d;
    logic [instWidth-1:0] inst_q, inst_d;
    logic [addrWidth-1:0] inst_pc_q, inst_pc_d;
    logic                 inst_valid_q, inst_valid_d;
    logic                 slot_free;
    logic                 load;

    assign slot_free    = !inst_valid_q || !bus.id_stall;
    assign bus.mem_addr = bus.PC + {{(addrWidth-2){1'b0}}, byte_cnt_q};
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_valid_q;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        buf_d        = buf_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        bus.mem_req  = 1'b0;
        bus.PC_stall = 1'b1;
        load         = 1'b0;

        if (bus.flush) begin
            // Any returning byte this cycle is dropped; refetch restarts at byte 0 of PC.
            state_d      = StFetch;
            byte_cnt_d   = 2'd0;
            buf_d        = '0;
            inst_valid_d = 1'b0;
        end else begin
            if (inst_valid_q && !bus.id_stall) begin
                inst_valid_d = 1'b0;
            end
            case (state_q)
                StIdle: begin
                    state_d    = StFetch;
                    byte_cnt_d = 2'd0;
                end
                StFetch: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_rvalid) begin
                        buf_d[{byte_cnt_q, 3'b000} +: 8] = bus.mem_rdata;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (slot_free) begin
                                load = 1'b1;
                            end else begin
                                state_d = StFull;
                            end
                        end
                    end
                end
                StFull: begin
                    if (slot_free) begin
                        load       = 1'b1;
                        state_d    = StFetch;
                        byte_cnt_d = 2'd0;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    byte_cnt_d = 2'd0;
                end
            endcase

            // Loading takes precedence over the consume clearing inst_valid.
            if (load) begin
                inst_d       = buf_d;
                inst_pc_d    = bus.PC;
                inst_valid_d = 1'b1;
                bus.PC_stall = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_cnt_q   <= 2'd0;
            buf_q        <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            buf_q        <= buf_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a PC unit that advances by 4 after each PC_stall=0 cycle
// and a byte memory answering in the same cycle as the request (or late, when told).
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.addrWidth(32), .instWidth(32)) bus ();

    inst_fetch #(.addrWidth(32), .instWidth(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem [32];
    logic [31:0] pc;
    logic        obs_req, obs_stall;
    logic [31:0] obs_addr;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_go  = 0;
    int          go_mark;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: present memory response, sample combinational outputs, clock, move PC.
    task automatic step(input bit rv);
        #1;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = mem[bus.mem_addr[4:0]];
        #1;
        obs_req   = bus.mem_req;
        obs_stall = bus.PC_stall;
        obs_addr  = bus.mem_addr;
        @(posedge clk);
        #1;
        if (obs_stall === 1'b0) begin
            pc += 4;
            n_go++;
        end
        bus.PC = pc;
    endtask

    task automatic fetch_word(input logic [31:0] base, input string tag);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check({tag, "_addr"}, obs_addr, base + k);
            check({tag, "_stall"}, {31'd0, obs_stall}, (k == 3) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] i, input logic [31:0] ipc,
                             input logic v);
        check({tag, "_inst"}, bus.inst, i);
        check({tag, "_pc"}, bus.inst_pc, ipc);
        check({tag, "_valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3]}     = {8'h13, 8'h05, 8'h10, 8'h00};
        {mem[4], mem[5], mem[6], mem[7]}     = {8'h93, 8'h05, 8'h20, 8'h00};
        {mem[8], mem[9], mem[10], mem[11]}   = {8'hb3, 8'h81, 8'h20, 8'h00};
        {mem[12], mem[13], mem[14], mem[15]} = {8'h33, 8'h82, 8'h41, 8'h40};
        {mem[16], mem[17], mem[18], mem[19]} = {8'h11, 8'h22, 8'h33, 8'h44};

        pc = 32'd0;
        bus.PC = pc;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.id_stall = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 8'h00;

        // Reset
        step(1'b0);
        step(1'b1);
        check("rst_req", {31'd0, obs_req}, 32'd0);
        check("rst_stall", {31'd0, obs_stall}, 32'd1);
        check("rst_addr", obs_addr, 32'd0);
        check_out("rst", 32'd0, 32'd0, 1'b0);

        // Idle cycle after reset, then first word from PC=0
        rst = 1'b0;
        step(1'b1);
        check("idle_req", {31'd0, obs_req}, 32'd0);
        check("idle_stall", {31'd0, obs_stall}, 32'd1);
        fetch_word(32'd0, "w0");
        check_out("w0", 32'h00100513, 32'd0, 1'b1);
        check("w0_pcadv", pc, 32'd4);

        // Second word back to back, decoder accepting
        go_mark = n_go;
        fetch_word(32'd4, "w1");
        check_out("w1", 32'h00200593, 32'd4, 1'b1);
        check("w1_gocnt", n_go - go_mark, 32'd1);

        // Decoder stalled while third word completes -> held in buffer
        bus.id_stall = 1'b1;
        go_mark = n_go;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check("w2_addr", obs_addr, 32'd8 + k);
            check("w2_stall", {31'd0, obs_stall}, 32'd1);
        end
        check_out("w2_held", 32'h00200593, 32'd4, 1'b1);
        step(1'b1);
        check("full_req", {31'd0, obs_req}, 32'd0);
        check("full_stall", {31'd0, obs_stall}, 32'd1);
        check_out("full", 32'h00200593, 32'd4, 1'b1);
        bus.id_stall = 1'b0;
        step(1'b1);
        check("full_load_req", {31'd0, obs_req}, 32'd0);
        check("full_load_stall", {31'd0, obs_stall}, 32'd0);
        check_out("w2", 32'h002081b3, 32'd8, 1'b1);
        check("w2_gocnt", n_go - go_mark, 32'd1);

        // Byte 1 of the fourth word arrives three cycles late
        step(1'b1);
        check("slow_b0", obs_addr, 32'd12);
        check("slow_stall0", {31'd0, obs_stall}, 32'd1);
        check("slow_consume", {31'd0, bus.inst_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            check("slow_wait_addr", obs_addr, 32'd13);
            check("slow_wait_req", {31'd0, obs_req}, 32'd1);
        end
        for (int k = 1; k < 4; k++) begin
            step(1'b1);
            check("slow_addr", obs_addr, 32'd12 + k);
            check("slow_stall", {31'd0, obs_stall}, (k == 3) ? 32'd0 : 32'd1);
        end
        check_out("w3", 32'h40418233, 32'd12, 1'b1);

        // Reset during byte 2 of the word at 16
        step(1'b1);
        step(1'b1);
        check("mid_addr", obs_addr, 32'd17);
        rst = 1'b1;
        step(1'b1);
        check_out("mid_rst", 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        pc = 32'd4;
        bus.PC = pc;
        step(1'b1);
        check("post_rst_req", {31'd0, obs_req}, 32'd0);
        check("post_rst_stall", {31'd0, obs_stall}, 32'd1);
        check("post_rst_addr", obs_addr, 32'd4);
        fetch_word(32'd4, "rw");
        check_out("rw", 32'h00200593, 32'd4, 1'b1);

        // Flush after two bytes at PC=8, with a valid instruction held
        bus.id_stall = 1'b1;
        step(1'b1);
        step(1'b1);
        check("fl_pre_addr", obs_addr, 32'd9);
        bus.flush = 1'b1;
        step(1'b1);
        check("fl_req", {31'd0, obs_req}, 32'd0);
        check("fl_stall", {31'd0, obs_stall}, 32'd1);
        check("fl_valid", {31'd0, bus.inst_valid}, 32'd0);
        bus.flush = 1'b0;
        bus.id_stall = 1'b0;
        fetch_word(32'd8, "fl");
        check_out("fl", 32'h002081b3, 32'd8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
